// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and bus-level constants for the I2C target
`timescale 1ns/1ps
package i2c_pkg;
   typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE} i2c_slv_state_e;
   localparam logic I2C_ACK  = 1'b0;
   localparam logic I2C_NACK = 1'b1;
endpackage

// File: rtl/i2c_slave_mem_if.sv
// i2c_slave_mem_if: memory write notifications and busy status of the I2C target
`timescale 1ns/1ps
interface i2c_slave_mem_if #(parameter int AW = 4);
   logic          wr_valid;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          busy;
   modport slave  (output wr_valid, wr_addr, wr_data, busy);
   modport master (input  wr_valid, wr_addr, wr_data, busy);
endinterface

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: synchronizer for one bus line with rise/fall detection on the synced value
`timescale 1ns/1ps
module i2c_line_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q,
   output logic rise,
   output logic fall
);
   logic [SYNC_STAGES:0] sr_q, sr_d;
   // shift the line through the sync stages plus one history stage
   always_comb sr_d = {sr_q[SYNC_STAGES-1:0], d};
   // reset to the idle-high bus level so no edge appears out of reset
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sr_q <= '1;
      else        sr_q <= sr_d;
   assign q    = sr_q[SYNC_STAGES-1];
   assign rise = q & ~sr_q[SYNC_STAGES];
   assign fall = ~q & sr_q[SYNC_STAGES];
endmodule

// File: rtl/i2c_slave_mem.sv
// i2c_slave_mem: I2C target with byte-addressed register memory and auto-incrementing pointer
`timescale 1ns/1ps
module i2c_slave_mem
   import i2c_pkg::*;
#(
   parameter logic [6:0] SLAVE_ADDR  = 7'b0010000,
   parameter int         MEM_DEPTH   = 16,
   parameter int         SYNC_STAGES = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   inout  wire            scl,
   inout  wire            sda,
   i2c_slave_mem_if.slave bus
);
   localparam int AW = $clog2(MEM_DEPTH);
   i2c_slv_state_e state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [7:0]    sh_q, sh_d, byte_in;
   logic [AW-1:0] ptr_q, ptr_d, wr_addr_q, wr_addr_d;
   logic [7:0]    mem_q [MEM_DEPTH];
   logic [7:0]    mem_d [MEM_DEPTH];
   logic [7:0]    wr_data_q, wr_data_d;
   logic          sda_oe_q, sda_oe_d, busy_q, busy_d, first_q, first_d, rw_q, rw_d, wr_valid_q, wr_valid_d;
   logic          scl_s, scl_rise, scl_fall, sda_s, sda_rise, sda_fall, start, stop;
   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
      .clk(clk), .rst_n(rst_n), .d(scl), .q(scl_s), .rise(scl_rise), .fall(scl_fall));
   i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
      .clk(clk), .rst_n(rst_n), .d(sda), .q(sda_s), .rise(sda_rise), .fall(sda_fall));
   assign start = sda_fall & scl_s;
   assign stop  = sda_rise & scl_s;
   // bus conditions override everything; otherwise bits move on scl rise and sda_oe on scl fall
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      sh_d       = sh_q;
      ptr_d      = ptr_q;
      mem_d      = mem_q;
      sda_oe_d   = sda_oe_q;
      busy_d     = busy_q;
      first_d    = first_q;
      rw_d       = rw_q;
      wr_valid_d = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      byte_in    = {sh_q[6:0], sda_s};
      if (start) begin
         state_d  = ADDR;
         cnt_d    = '0;
         sda_oe_d = 1'b0;
      end else if (stop) begin
         state_d  = IDLE;
         sda_oe_d = 1'b0;
         busy_d   = 1'b0;
      end else begin
         case (state_q)
            ADDR: if (scl_rise) begin
               sh_d  = byte_in;
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd7) begin
                  state_d = byte_in[7:1] == SLAVE_ADDR ? ADDR_ACK : IGNORE;
                  busy_d  = byte_in[7:1] == SLAVE_ADDR;
                  rw_d    = byte_in[0];
               end
            end
            ADDR_ACK: if (scl_fall) begin
               if (!sda_oe_q) sda_oe_d = 1'b1;
               else if (rw_q) begin
                  state_d  = RD_BYTE;
                  cnt_d    = '0;
                  sh_d     = {mem_q[ptr_q][6:0], 1'b0};
                  sda_oe_d = ~mem_q[ptr_q][7];
               end else begin
                  state_d  = WR_BYTE;
                  cnt_d    = '0;
                  first_d  = 1'b1;
                  sda_oe_d = 1'b0;
               end
            end
            WR_BYTE: if (scl_rise) begin
               sh_d  = byte_in;
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == 4'd7) begin
                  state_d = WR_ACK;
                  first_d = 1'b0;
                  if (first_q) ptr_d = byte_in[AW-1:0];
                  else begin
                     mem_d[ptr_q] = byte_in;
                     wr_valid_d   = 1'b1;
                     wr_addr_d    = ptr_q;
                     wr_data_d    = byte_in;
                     ptr_d        = ptr_q + AW'(1);
                  end
               end
            end
            WR_ACK: if (scl_fall) begin
               sda_oe_d = ~sda_oe_q;
               if (sda_oe_q) begin
                  state_d = WR_BYTE;
                  cnt_d   = '0;
               end
            end
            RD_BYTE: if (scl_rise) cnt_d = cnt_q + 4'd1;
               else if (scl_fall) begin
                  sda_oe_d = cnt_q == 4'd8 ? 1'b0 : ~sh_q[7];
                  sh_d     = {sh_q[6:0], 1'b0};
                  state_d  = cnt_q == 4'd8 ? RD_ACK : RD_BYTE;
               end
            RD_ACK: if (scl_rise) begin
               ptr_d   = ptr_q + AW'(1);
               state_d = sda_s == I2C_ACK ? RD_BYTE : IGNORE;
               cnt_d   = '0;
               sh_d    = mem_q[ptr_d];
            end
            default: ;
         endcase
      end
   end
   // register everything; async reset also releases sda at once
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         sh_q       <= '0;
         ptr_q      <= '0;
         mem_q      <= '{default: '0};
         sda_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         first_q    <= 1'b0;
         rw_q       <= 1'b0;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sh_q       <= sh_d;
         ptr_q      <= ptr_d;
         mem_q      <= mem_d;
         sda_oe_q   <= sda_oe_d;
         busy_q     <= busy_d;
         first_q    <= first_d;
         rw_q       <= rw_d;
         wr_valid_q <= wr_valid_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   assign sda          = sda_oe_q ? 1'b0 : 1'bz;
   assign bus.wr_valid = wr_valid_q;
   assign bus.wr_addr  = wr_addr_q;
   assign bus.wr_data  = wr_data_q;
   assign bus.busy     = busy_q;
endmodule
